// File: rtl/rvfi_commit_serializer.sv
// Multi-lane RVFI commit serializer: drops NOPs, buffers retirements in program order, replays one per cycle.
// Optional PC-continuity checking is built only when RVFI_PC_CHECK_EN is defined.
module rvfi_commit_serializer #(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0]      lane_valid,
  input  logic [LANES*32-1:0]   lane_inst,
  input  logic [LANES*XLEN-1:0] lane_pc_rdata,
  input  logic [LANES*XLEN-1:0] lane_pc_wdata,
  input  logic [LANES-1:0]      lane_load_regfile,
  input  logic [LANES*5-1:0]    lane_rd_addr,
  input  logic [LANES*XLEN-1:0] lane_rd_wdata,
  output logic                  stall,
  output logic                  commit,
  output logic [63:0]           order,
  output logic [31:0]           inst,
  output logic [XLEN-1:0]       pc_rdata,
  output logic [XLEN-1:0]       pc_wdata,
  output logic                  load_regfile,
  output logic [4:0]            rd_addr,
  output logic [XLEN-1:0]       rd_wdata,
  output logic                  halt,
  output logic                  halted,
  output logic                  overflow,
  output logic                  pc_mismatch
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic            load_regfile;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d, n_acc;
  logic [LANES-1:0] lane_ok;
  logic [PW-1:0]   slot [LANES];
  logic            enq, pop, head_halt;
  entry_t          head, out_q;
  logic [63:0]     ord_cnt_q, order_q;
  logic            commit_q, halt_q, halted_q, ovf_q;

  assign stall     = (CW'(DEPTH) - count_q) < CW'(LANES);
  assign enq       = !stall && !halted_q;
  assign pop       = count_q != '0;
  assign head      = mem_q[rd_ptr_q];
  assign head_halt = (head.inst[6:0] == 7'b1100011) &&
                     (head.inst[19:15] == head.inst[24:20]) &&
                     (head.pc_wdata == head.pc_rdata);

  // Compact surviving lanes into consecutive slots, oldest lane first.
  always_comb begin
    n_acc = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_ok[i] = lane_valid[i] && (lane_inst[32*i +: 32] != NOP);
      slot[i]    = wr_ptr_q + PW'(n_acc);
      n_acc      = n_acc + CW'(lane_ok[i]);
    end
    count_d  = count_q + (enq ? n_acc : '0) - CW'(pop);
    wr_ptr_d = wr_ptr_q + (enq ? PW'(n_acc) : '0);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (lane_ok[i]) begin
          mem_q[slot[i]] <= '{inst:         lane_inst[32*i +: 32],
                              pc_rdata:     lane_pc_rdata[XLEN*i +: XLEN],
                              pc_wdata:     lane_pc_wdata[XLEN*i +: XLEN],
                              load_regfile: lane_load_regfile[i],
                              rd_addr:      lane_rd_addr[5*i +: 5],
                              rd_wdata:     lane_rd_wdata[XLEN*i +: XLEN]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_q     <= '0;
      ord_cnt_q <= '0;
      order_q   <= '0;
      commit_q  <= 1'b0;
      halt_q    <= 1'b0;
      halted_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      commit_q <= pop;
      halt_q   <= pop && head_halt;
      if (pop) begin
        out_q     <= head;
        order_q   <= ord_cnt_q;
        ord_cnt_q <= ord_cnt_q + 64'd1;
        if (head_halt) halted_q <= 1'b1;
      end
      if ((|lane_valid) && (stall || halted_q)) ovf_q <= 1'b1;
    end
  end

  assign commit       = commit_q;
  assign order        = order_q;
  assign inst         = out_q.inst;
  assign pc_rdata     = out_q.pc_rdata;
  assign pc_wdata     = out_q.pc_wdata;
  assign load_regfile = out_q.load_regfile;
  assign rd_addr      = out_q.rd_addr;
  assign rd_wdata     = out_q.rd_wdata;
  assign halt         = halt_q;
  assign halted       = halted_q;
  assign overflow     = ovf_q;

`ifdef RVFI_PC_CHECK_EN
  logic [XLEN-1:0] last_pc_q;
  logic            seen_q, pcm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc_q <= '0;
      seen_q    <= 1'b0;
      pcm_q     <= 1'b0;
    end else if (pop) begin
      last_pc_q <= head.pc_wdata;
      seen_q    <= 1'b1;
      if (seen_q && (head.pc_rdata != last_pc_q)) pcm_q <= 1'b1;
    end
  end

  assign pc_mismatch = pcm_q;
`else
  assign pc_mismatch = 1'b0;
`endif

endmodule
